// File: rtl/ahbl_splitter_pkg.sv
// Shared AHB-Lite encodings and decode-error FSM state type for the 1:N splitter.
package ahbl_splitter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } decerr_state_t;

endpackage

// File: rtl/ahbl_splitter_if.sv
// AHB-Lite bundle; N lanes are packed side by side with lane 0 in the LSBs.
interface ahbl_splitter_if #(
    parameter int N      = 1,
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [N*W_ADDR-1:0] d_pc;
    logic [N-1:0]        hready;
    logic [N-1:0]        hready_resp;
    logic [N-1:0]        hresp;
    logic [N*W_ADDR-1:0] haddr;
    logic [N-1:0]        hwrite;
    logic [N*2-1:0]      htrans;
    logic [N*3-1:0]      hsize;
    logic [N*3-1:0]      hburst;
    logic [N*4-1:0]      hprot;
    logic [N-1:0]        hmastlock;
    logic [N*W_DATA-1:0] hwdata;
    logic [N*W_DATA-1:0] hrdata;
    logic [N-1:0]        hexcl;
    logic [N*8-1:0]      hmaster;
    logic [N-1:0]        hexokay;

    modport master (
        output d_pc, hready, haddr, hwrite, htrans, hsize, hburst, hprot,
               hmastlock, hwdata, hexcl, hmaster,
        input  hready_resp, hresp, hrdata, hexokay
    );

    modport slave (
        input  d_pc, hready, haddr, hwrite, htrans, hsize, hburst, hprot,
               hmastlock, hwdata, hexcl, hmaster,
        output hready_resp, hresp, hrdata, hexokay
    );
endinterface

// File: rtl/ahbl_decerr_responder.sv
// Two-cycle AHB ERROR response for transfers that decode to no slave.
module ahbl_decerr_responder
    import ahbl_splitter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_hready,
    input  logic i_unmapped,
    output logic o_hready_resp,
    output logic o_hresp
);

    decerr_state_t r_state;
    decerr_state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // ERR2 may chain straight into a new error when another unmapped transfer is accepted.
    always_comb begin
        w_next        = r_state;
        o_hready_resp = 1'b1;
        o_hresp       = HRESP_OKAY;
        case (r_state)
            ST_IDLE: begin
                if (i_hready && i_unmapped) w_next = ST_ERR1;
            end
            ST_ERR1: begin
                o_hready_resp = 1'b0;
                o_hresp       = HRESP_ERROR;
                w_next        = ST_ERR2;
            end
            ST_ERR2: begin
                o_hresp = HRESP_ERROR;
                w_next  = (i_hready && i_unmapped) ? ST_ERR1 : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/ahbl_splitter.sv
// 1:N AHB-Lite address-decoding splitter with data-phase response routing.
// Define AHBL_SPLITTER_DECERR_EN to give unmapped transfers an ERROR response.
module ahbl_splitter
    import ahbl_splitter_pkg::*;
#(
    parameter int                        N_PORTS   = 2,
    parameter int                        W_ADDR    = 32,
    parameter int                        W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
    parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0,
    parameter logic [N_PORTS-1:0]        CONN_MASK = '1
) (
    input logic            clk,
    input logic            rst_n,
    ahbl_splitter_if.slave  src,
    ahbl_splitter_if.master dst
);

    logic [N_PORTS-1:0] w_match;
    logic [N_PORTS-1:0] w_sel_a;
    logic [N_PORTS-1:0] r_sel_d;
    logic               w_mux_ready;
    logic               w_mux_resp;
    logic [W_DATA-1:0]  w_mux_rdata;
    logic               w_mux_exokay;
    logic               w_dec_ready;
    logic               w_dec_resp;

    // Scanning downward leaves the lowest matching port as the winner on overlap.
    always_comb begin
        w_match = '0;
        w_sel_a = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_match[i] = ((src.haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR])
                         && CONN_MASK[i];
        end
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_sel_a    = '0;
                w_sel_a[i] = 1'b1;
            end
        end
    end

    assign dst.d_pc      = {N_PORTS{src.d_pc}};
    assign dst.hready    = {N_PORTS{src.hready}};
    assign dst.haddr     = {N_PORTS{src.haddr}};
    assign dst.hwrite    = {N_PORTS{src.hwrite}};
    assign dst.hsize     = {N_PORTS{src.hsize}};
    assign dst.hburst    = {N_PORTS{src.hburst}};
    assign dst.hprot     = {N_PORTS{src.hprot}};
    assign dst.hmastlock = {N_PORTS{src.hmastlock}};
    assign dst.hwdata    = {N_PORTS{src.hwdata}};
    assign dst.hexcl     = {N_PORTS{src.hexcl}};
    assign dst.hmaster   = {N_PORTS{src.hmaster}};

    for (genvar g = 0; g < N_PORTS; g++) begin : g_trans
        assign dst.htrans[2*g +: 2] = w_sel_a[g] ? src.htrans : HTRANS_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_sel_d <= '0;
        else if (src.hready) r_sel_d <= w_sel_a & {N_PORTS{src.htrans[1]}};
    end

    always_comb begin
        w_mux_ready  = 1'b0;
        w_mux_resp   = 1'b0;
        w_mux_rdata  = '0;
        w_mux_exokay = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_sel_d[i]) begin
                w_mux_ready  = w_mux_ready  | dst.hready_resp[i];
                w_mux_resp   = w_mux_resp   | dst.hresp[i];
                w_mux_rdata  = w_mux_rdata  | dst.hrdata[i*W_DATA +: W_DATA];
                w_mux_exokay = w_mux_exokay | dst.hexokay[i];
            end
        end
    end

`ifdef AHBL_SPLITTER_DECERR_EN
    logic w_unmapped;
    assign w_unmapped = src.htrans[1] && !(|w_sel_a);

    ahbl_decerr_responder u_decerr (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_hready      (src.hready),
        .i_unmapped    (w_unmapped),
        .o_hready_resp (w_dec_ready),
        .o_hresp       (w_dec_resp)
    );
`else
    assign w_dec_ready = 1'b1;
    assign w_dec_resp  = HRESP_OKAY;
`endif

    assign src.hready_resp = (|r_sel_d) ? w_mux_ready : w_dec_ready;
    assign src.hresp       = (|r_sel_d) ? w_mux_resp  : w_dec_resp;
    assign src.hrdata      = w_mux_rdata;
    assign src.hexokay     = w_mux_exokay;

endmodule

// File: doc/ahbl_splitter.md
Name: ahbl_splitter

Overview:
- 1:N AHB-Lite address-decoding splitter: one master-facing slave port fans out to N slave-facing master ports.
- Counterpart of the N:1 strict-priority arbiter; an arbiter output typically feeds this block's src port.
- Decodes each address phase against a static address map and routes the data-phase response back from the selected slave.
- Carries the exclusive-access sideband (hexcl/hmaster/hexokay) and the debug d_pc.
- Unmapped accesses are absorbed internally.

Parameters:
- N_PORTS, 2, number of downstream slave ports.
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- ADDR_MAP, {N_PORTS*W_ADDR} zeros, concatenated base address per port; port 0 in the LSBs.
- ADDR_MASK, {N_PORTS*W_ADDR} zeros, concatenated decode mask per port.
- CONN_MASK, {N_PORTS{1'b1}}, 0 disables the port; it never decodes.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_d_pc  in  W_ADDR  debug PC of the current address phase
- src_hready  in  1  bus hready, address-phase advance
- src_hready_resp  out  1  data-phase ready to master
- src_hresp  out  1  data-phase error to master
- src_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock  in  W_ADDR/1/2/3/3/4/1  address phase
- src_hwdata  in  W_DATA  write data
- src_hrdata  out  W_DATA  read data
- src_hexcl  in  1  exclusive access request
- src_hmaster  in  8  master ID
- src_hexokay  out  1  exclusive success
- dst_d_pc  out  N_PORTS*W_ADDR  broadcast
- dst_hready  out  N_PORTS  broadcast src_hready
- dst_hready_resp  in  N_PORTS  per-slave ready
- dst_hresp  in  N_PORTS  per-slave error
- dst_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock  out  N_PORTS* widths above  address phase
- dst_hwdata  out  N_PORTS*W_DATA  broadcast
- dst_hrdata  in  N_PORTS*W_DATA  per-slave read data
- dst_hexcl  out  N_PORTS  broadcast
- dst_hmaster  out  N_PORTS*8  broadcast
- dst_hexokay  in  N_PORTS  per-slave exclusive okay

Behaviour:
- Decode:
  - match[i] = ((src_haddr & ADDR_MASK[i]) == ADDR_MAP[i]) && CONN_MASK[i].
  - sel_a = onehot_priority(match); the lowest index wins on overlap.
  - unmapped = src_htrans[1] && !|sel_a.
- Address phase:
  - All address-phase signals, hwdata, hexcl, hmaster and d_pc are broadcast to every port.
  - dst_htrans[i] = sel_a[i] ? src_htrans : IDLE (2'b00), so BUSY also reaches the decoded slave.
  - dst_hready[i] = src_hready.
- Data-phase select register sel_d (N_PORTS bits):
  - Reset 0.
  - On src_hready: sel_d <= sel_a & {N{src_htrans[1]}}.
  - Otherwise sel_d holds.
- Response mux (onehot_mux by sel_d) drives src_hready_resp, src_hresp, src_hrdata and src_hexokay.
  - With sel_d == 0 and FSM in IDLE: hready_resp=1, hresp=0, hrdata=0, hexokay=0.
- Decode-error FSM:
  - States: IDLE, ERR1, ERR2.
  - IDLE -> ERR1 when src_hready && unmapped.
  - ERR1: hready_resp=0, hresp=1; always -> ERR2.
  - ERR2: hready_resp=1, hresp=1. -> ERR1 if src_hready && unmapped, else -> IDLE.
  - An active transfer to a mapped slave from ERR2 sets sel_d normally.
- Latency: zero added cycles. The address phase is combinational passthrough; the response is a combinational mux.
- Master drops htrans to IDLE during ERR1: legal. No address is accepted, since src_hready=0.
- Reset outputs: src_hready_resp=1, src_hresp=0, src_hrdata=0, src_hexokay=0. dst_* follow src inputs combinationally, with dst_htrans=IDLE unless decoded.
- Reset mid-transfer: sel_d and FSM clear immediately (asynchronously); any in-flight data phase is abandoned.

Optional Feature:
- AHBL_SPLITTER_DECERR_EN defined: unmapped active transfers take the two-cycle ERROR response above.
- Undefined: the FSM is removed. Unmapped transfers complete as a zero-wait OKAY, with hrdata=0 and writes discarded.

Decomposition:
- Shared ahbl package holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - FSM state encoding
- Reuse the existing onehot_priority and onehot_mux.
- One new sub-module, ahbl_decerr_responder: FSM plus its hready_resp/hresp outputs, instantiated only under AHBL_SPLITTER_DECERR_EN.

Test Plan (N_PORTS=2, ADDR_MAP={32'h4000_0000,32'h0000_0000}, ADDR_MASK={32'hf000_0000,32'hf000_0000}):
- Read 0x0000_0010 NONSEQ, slave0 returns 32'hdead_beef with 1 wait state -> dst_htrans=2'b10 on port0 only; src_hready_resp low 1 cycle; src_hrdata=32'hdead_beef.
- Back-to-back write 0x4000_0004 then read 0x0000_0008 -> hwdata phase routed to port1 response, then read response from port0; sel_d toggles 2'b10 -> 2'b01.
- Read 0x8000_0000 with DECERR_EN -> cycle+1: hready_resp=0, hresp=1; cycle+2: hready_resp=1, hresp=1; no dst_htrans active. Without DECERR_EN -> OKAY, hrdata=0.
- Exclusive read 0x4000_0000 with hexcl=1, hmaster=8'h03, slave1 hexokay=1 -> dst_hexcl=1, dst_hmaster=8'h03, src_hexokay=1.
- CONN_MASK=2'b01, access 0x4000_0000 -> treated as unmapped (error sequence).
- Assert rst_n low during a slave1 wait state -> sel_d=0 and hready_resp=1 immediately; the next transfer after release decodes normally.
